// File: rtl/gf2m_digit_mult_if.sv
// Handshake and operand/result bundle for the GF(2^M) digit-serial multiplier.
//   m_start  initiator -> responder  start request (level, held until m_done)
//   a, b     initiator -> responder  operands, sampled on the acceptance edge
//   c        responder -> initiator  product register
//   m_done   responder -> initiator  one-cycle completion pulse
//   busy     responder -> initiator  operation in progress
//   m_err    responder -> initiator  protocol-abort pulse (only with GF2M_PROTOCOL_ERR_EN)
// Optional feature macro: GF2M_PROTOCOL_ERR_EN
interface gf2m_digit_mult_if #(
   parameter int unsigned M = 163
);
   logic         m_start;
   logic [M-1:0] a;
   logic [M-1:0] b;
   logic [M-1:0] c;
   logic         m_done;
   logic         busy;
`ifdef GF2M_PROTOCOL_ERR_EN
   logic         m_err;
`endif

   modport master (
      output m_start,
      output a,
      output b,
`ifdef GF2M_PROTOCOL_ERR_EN
      input  m_err,
`endif
      input  c,
      input  m_done,
      input  busy
   );

   modport slave (
      input  m_start,
      input  a,
      input  b,
`ifdef GF2M_PROTOCOL_ERR_EN
      output m_err,
`endif
      output c,
      output m_done,
      output busy
   );
endinterface

// File: rtl/gf2m_digit_mult.sv
// Digit-serial GF(2^M) multiplier, polynomial basis, f(x) = x^M + POLY.
// Responder side of the m_start/m_done handshake. On acceptance the operands are
// latched; each RUN cycle consumes one D-bit digit of b, MSB digit first:
//   acc' = (acc * x^D + ra * digit) mod f
// After NDIG = ceil(M/D) iterations the product is written to c with a one-cycle
// m_done pulse. The FSM then waits in HOLD until m_start is released, so a
// level-held start never launches a second operation.
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  synchronous active-low reset
//   bus    gf2m_digit_mult_if slave modport (m_start, a, b, c, m_done, busy[, m_err])
// Optional feature macro: GF2M_PROTOCOL_ERR_EN
//   When defined, dropping m_start during RUN aborts the operation (c unchanged,
//   no m_done) and pulses bus.m_err for one cycle.
module gf2m_digit_mult #(
   parameter int unsigned  M    = 163,
   parameter int unsigned  D    = 4,
   parameter logic [M-1:0] POLY = 163'hC9
) (
   input logic              clk,
   input logic              rst_n,
   gf2m_digit_mult_if.slave bus
);
   localparam int unsigned NDIG = (M + D - 1) / D;
   localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int unsigned RBW  = NDIG * D;

   localparam logic [M+D-1:0] POLY_EXT = {{D{1'b0}}, POLY};

   typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

   state_e         state_q;
   logic [M-1:0]   ra_q;
   logic [RBW-1:0] rb_q;
   logic [M-1:0]   acc_q;
   logic [CW-1:0]  cnt_q;

   logic [D-1:0]   digit;
   logic [M+D-1:0] ra_ext;
   logic [M+D-1:0] wide;
   logic [M-1:0]   acc_d;

   // One iteration: shift, add partial product, then fold the overflow bits.
   // Bits are folded from the top down so that any term a fold pushes back to
   // degree >= M is folded again by a later (lower) step.
   always_comb begin
      digit  = rb_q[cnt_q*D +: D];
      ra_ext = {{D{1'b0}}, ra_q};
      wide   = {acc_q, {D{1'b0}}};
      for (int j = 0; j < int'(D); j++) begin
         if (digit[j]) begin
            wide = wide ^ (ra_ext << j);
         end
      end
      for (int i = int'(M + D) - 1; i >= int'(M); i--) begin
         if (wide[i]) begin
            wide[i] = 1'b0;
            wide    = wide ^ (POLY_EXT << (i - int'(M)));
         end
      end
      acc_d = wide[M-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ra_q        <= '0;
         rb_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         bus.c       <= '0;
         bus.m_done  <= 1'b0;
         bus.busy    <= 1'b0;
`ifdef GF2M_PROTOCOL_ERR_EN
         bus.m_err   <= 1'b0;
`endif
      end else begin
         bus.m_done <= 1'b0;
`ifdef GF2M_PROTOCOL_ERR_EN
         bus.m_err  <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (bus.m_start) begin
                  ra_q     <= bus.a;
                  rb_q     <= RBW'(bus.b);
                  acc_q    <= '0;
                  cnt_q    <= CW'(NDIG - 1);
                  bus.busy <= 1'b1;
                  state_q  <= StRun;
               end
            end
            StRun: begin
`ifdef GF2M_PROTOCOL_ERR_EN
               if (!bus.m_start) begin
                  // Initiator withdrew mid-operation: abandon without touching c.
                  bus.busy  <= 1'b0;
                  bus.m_err <= 1'b1;
                  state_q   <= StIdle;
               end else
`endif
               begin
                  acc_q <= acc_d;
                  if (cnt_q == '0) begin
                     bus.c      <= acc_d;
                     bus.m_done <= 1'b1;
                     bus.busy   <= 1'b0;
                     state_q    <= StHold;
                  end else begin
                     cnt_q <= cnt_q - CW'(1);
                  end
               end
            end
            StHold: begin
               // Re-arm only after m_start has been released.
               if (!bus.m_start) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_gf2m_digit_mult.sv
// Self-checking bench for gf2m_digit_mult: directed vectors with hand-computed
// products, handshake/latency checks on the D=4 instance, and random products
// on D=1, D=4 and D=16 instances against a bit-serial reference.
module tb_gf2m_digit_mult;
   localparam int M = 163;
   localparam logic [M-1:0] POLY = 163'hC9;

   logic         clk;
   logic         rst_n;
   logic         m_start;
   logic [M-1:0] a;
   logic [M-1:0] b;

   int n_vec = 0;
   int n_err = 0;
   int done1 = 0, done4 = 0, done16 = 0;
   logic [M-1:0] c1_last, c4_last, c16_last;

   gf2m_digit_mult_if #(.M(M)) if1  ();
   gf2m_digit_mult_if #(.M(M)) if4  ();
   gf2m_digit_mult_if #(.M(M)) if16 ();

   assign if1.m_start  = m_start;
   assign if1.a        = a;
   assign if1.b        = b;
   assign if4.m_start  = m_start;
   assign if4.a        = a;
   assign if4.b        = b;
   assign if16.m_start = m_start;
   assign if16.a       = a;
   assign if16.b       = b;

   gf2m_digit_mult #(.M(M), .D(1), .POLY(POLY)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );
   gf2m_digit_mult #(.M(M), .D(4), .POLY(POLY)) u_dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if4)
   );
   gf2m_digit_mult #(.M(M), .D(16), .POLY(POLY)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (if1.m_done)  begin done1++;  c1_last  = if1.c;  end
      if (if4.m_done)  begin done4++;  c4_last  = if4.c;  end
      if (if16.m_done) begin done16++; c16_last = if16.c; end
   end

   task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [M-1:0] xpow(input int n);
      logic [M-1:0] r;
      r    = '0;
      r[n] = 1'b1;
      return r;
   endfunction

   function automatic logic [M-1:0] rnd();
      logic [191:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      return t[M-1:0];
   endfunction

   // Bit-serial reference: Horner over the bits of y, MSB first.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
      logic [M-1:0] r;
      r = '0;
      for (int i = M - 1; i >= 0; i--) begin
         r = r[M-1] ? ((r << 1) ^ POLY) : (r << 1);
         if (y[i]) r = r ^ x;
      end
      return r;
   endfunction

   // One operation observed on the D=4 instance; operands are scrambled after acceptance.
   task automatic op4(input logic [M-1:0] oa, input logic [M-1:0] ob,
                      output logic [M-1:0] oc, output logic ok);
      ok = 1'b0;
      oc = '0;
      @(posedge clk); #1;
      a = oa; b = ob; m_start = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            a = {M{1'b1}};
            b = {M{1'b1}};
         end
         if (if4.m_done) begin
            oc = if4.c;
            ok = 1'b1;
            break;
         end
      end
      m_start = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; m_start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [M-1:0] got, ra, rb, c_prev;
      logic         ok;
      int           done_k, busy_gaps, d0, d1, d4, d16;

      rst_n = 1'b0; m_start = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset c", if4.c, '0);
      check("reset m_done", M'(if4.m_done), '0);
      check("reset busy", M'(if4.busy), '0);
      rst_n = 1'b1;

      // 1 * 1: latency, busy window, result
      d0 = done4;
      @(posedge clk); #1;
      a = 1; b = 1; m_start = 1'b1;
      @(posedge clk); #1;  // acceptance edge E0 just passed
      check("busy after accept", M'(if4.busy), 1);
      done_k = 0; busy_gaps = 0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk); #1;
         if (if4.m_done) begin
            done_k = k;
            break;
         end
         if (!if4.busy) busy_gaps++;
      end
      check("latency", M'(done_k), 41);
      check("busy gaps", M'(busy_gaps), 0);
      check("1*1", if4.c, 1);
      check("busy at done", M'(if4.busy), 0);

      // level-held start: no second operation
      repeat (10) @(posedge clk);
      #1;
      check("single done while held", M'(done4 - d0), 1);
      check("idle while held", M'(if4.busy), 0);
      check("c held", if4.c, 1);

      // release for one cycle, raise again with x^162 * x
      m_start = 1'b0;
      @(posedge clk); #1;
      a = xpow(162); b = xpow(1); m_start = 1'b1;
      @(posedge clk); #1;
      check("rearm busy", M'(if4.busy), 1);
      ok = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(posedge clk); #1;
         if (if4.m_done) begin
            ok = 1'b1;
            break;
         end
      end
      check("rearm done", M'(ok), 1);
      check("x^162*x", if4.c, 163'hC9);
      m_start = 1'b0;
      @(posedge clk); #1;

      // directed products
      rb = rnd();
      op4('0, rb, got, ok);                 check("0*b done", M'(ok), 1); check("0*b", got, '0);
      op4(rb, '0, got, ok);                 check("a*0 done", M'(ok), 1); check("a*0", got, '0);
      op4(163'h3, 163'h5, got, ok);         check("3*5", got, 163'hF);
      op4(xpow(100), xpow(62), got, ok);    check("x^100*x^62", got, xpow(162));
      op4(xpow(162), xpow(2), got, ok);     check("x^162*x^2", got, 163'h192);
      op4(xpow(162), xpow(162), got, ok);
      check("x^162*x^162", got, xpow(161) | 163'h1422);

      // reset during RUN cycle 20
      c_prev = if4.c;
      @(posedge clk); #1;
      a = xpow(5); b = xpow(7); m_start = 1'b1;
      @(posedge clk);                       // E0
      repeat (19) @(posedge clk);
      #1;
      rst_n = 1'b0; m_start = 1'b0;
      d0 = done4;
      @(posedge clk); #1;
      check("rst mid busy", M'(if4.busy), 0);
      check("rst mid m_done", M'(if4.m_done), 0);
      check("rst mid c", if4.c, '0);
      check("prior c nonzero", M'(c_prev != '0), 1);
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("no done after rst", M'(done4 - d0), 0);
      ra = rnd(); rb = rnd();
      op4(ra, rb, got, ok);
      check("op after rst", got, gf_mul(ra, rb));

`ifdef GF2M_PROTOCOL_ERR_EN
      // protocol abort at RUN cycle 5
      c_prev = if4.c;
      d0     = done4;
      @(posedge clk); #1;
      a = rnd(); b = rnd(); m_start = 1'b1;
      @(posedge clk);                       // E0
      repeat (4) @(posedge clk);
      #1;
      m_start = 1'b0;
      @(posedge clk); #1;
      check("m_err pulse", M'(if4.m_err), 1);
      check("err busy", M'(if4.busy), 0);
      check("err c kept", if4.c, c_prev);
      @(posedge clk); #1;
      check("m_err one cycle", M'(if4.m_err), 0);
      repeat (50) @(posedge clk);
      #1;
      check("no done after err", M'(done4 - d0), 0);
      check("err c still kept", if4.c, c_prev);
`endif

      // random products on all digit sizes
      pulse_reset();
      for (int n = 0; n < 40; n++) begin
         ra = rnd(); rb = rnd();
         d1 = done1; d4 = done4; d16 = done16;
         @(posedge clk); #1;
         a = ra; b = rb; m_start = 1'b1;
         @(posedge clk); #1;
         a = ~ra; b = ~rb;
         for (int k = 0; k < 400; k++) begin
            if (done1 > d1 && done4 > d4 && done16 > d16) break;
            @(posedge clk); #1;
         end
         check("rand all done", M'(done1 > d1 && done4 > d4 && done16 > d16), 1);
         m_start = 1'b0;
         @(posedge clk); #1;
         check("rand D=1", c1_last, gf_mul(ra, rb));
         check("rand D=4", c4_last, gf_mul(ra, rb));
         check("rand D=16", c16_last, gf_mul(ra, rb));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
